// File: rtl/powlib_bus_pkg.sv
// Shared bus helpers: window-hit decode, clog2, and {addr,data} word layout
// used by the bus FIFOs.
package powlib_bus_pkg;

    localparam int unsigned BUS_AW_MAX   = 32;
    localparam int unsigned BUS_DATA_OFS = 0;

    // Address field sits directly above the data field in a bus FIFO word.
    function automatic int unsigned bus_addr_ofs(input int unsigned dw);
        return BUS_DATA_OFS + dw;
    endfunction

    function automatic int unsigned bus_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // One extra bit so a window ending at 2^AW does not wrap to zero.
    function automatic logic bus_win_hit(input logic [BUS_AW_MAX-1:0] addr,
                                         input logic [BUS_AW_MAX-1:0] base,
                                         input logic [BUS_AW_MAX-1:0] size);
        logic [BUS_AW_MAX:0] a;
        logic [BUS_AW_MAX:0] b;
        logic [BUS_AW_MAX:0] e;
        a = {1'b0, addr};
        b = {1'b0, base};
        e = b + {1'b0, size};
        return (a >= b) && (a < e);
    endfunction

endpackage

// File: rtl/powlib_busroute_buf.sv
// Per-output D-deep FIFO for the bus router; a full FIFO refuses pushes even
// when a pop happens in the same cycle, and there is no bypass path.
module powlib_busroute_buf
    import powlib_bus_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_push,
    output logic         o_full,
    output logic [W-1:0] o_data,
    output logic         o_vld,
    input  logic         i_pop
);

    localparam int unsigned PW = bus_clog2(D);

    logic [W-1:0]  r_mem [D];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full = (r_count == (PW+1)'(D));
    assign o_vld  = (r_count != '0);
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && o_vld;
    assign o_data = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/powlib_busroute.sv
// Single-writer, multi-reader bus router: decodes each beat against B_RDS
// address windows and queues it per output. Optional drop counter under
// POWLIB_BUSROUTE_ERRCNT_EN; otherwise errcnt is tied to zero.
module powlib_busroute
    import powlib_bus_pkg::*;
#(
    parameter string       ID      = "BUSROUTE",
    parameter int unsigned EDBG    = 0,
    parameter int unsigned B_RDS   = 4,
    parameter int unsigned B_AW    = 2,
    parameter int unsigned B_DW    = 4,
    parameter int unsigned D       = 2,
    parameter int unsigned EW      = 8,
    parameter logic [B_RDS*B_AW-1:0] B_BASES = '0,
    parameter logic [B_RDS*B_AW-1:0] B_SIZES = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [B_DW-1:0]         wrdata,
    input  logic [B_AW-1:0]         wraddr,
    input  logic                    wrvld,
    output logic                    wrrdy,
    output logic [B_RDS*B_DW-1:0]   rddatas,
    output logic [B_RDS*B_AW-1:0]   rdaddrs,
    output logic [B_RDS-1:0]        rdvlds,
    input  logic [B_RDS-1:0]        rdrdys,
    output logic [EW-1:0]           errcnt
);

    localparam int unsigned WW       = B_AW + B_DW;
    localparam int unsigned ADDR_OFS = bus_addr_ofs(B_DW);

    logic [B_RDS-1:0] w_hit;
    logic [B_RDS-1:0] w_sel;
    logic [B_RDS-1:0] w_full;
    logic [B_RDS-1:0] w_push;
    logic             w_any;
    logic             w_xfer;
    logic [WW-1:0]    w_word_in;
    logic [WW-1:0]    w_word [B_RDS];

    // Isolating the lowest set bit gives lowest-index priority on overlap.
    assign w_sel     = w_hit & (~w_hit + 1'b1);
    assign w_any     = |w_hit;
    assign wrrdy     = rst && (!w_any || !(|(w_sel & w_full)));
    assign w_xfer    = wrvld && wrrdy;
    assign w_push    = w_xfer ? w_sel : '0;
    assign w_word_in = {wraddr, wrdata};

    for (genvar j = 0; j < B_RDS; j++) begin : g_port
        assign w_hit[j] = bus_win_hit(BUS_AW_MAX'(wraddr),
                                      BUS_AW_MAX'(B_BASES[j*B_AW +: B_AW]),
                                      BUS_AW_MAX'(B_SIZES[j*B_AW +: B_AW]));

        powlib_busroute_buf #(
            .W (WW),
            .D (D)
        ) u_buf (
            .clk    (clk),
            .rst    (rst),
            .i_data (w_word_in),
            .i_push (w_push[j]),
            .o_full (w_full[j]),
            .o_data (w_word[j]),
            .o_vld  (rdvlds[j]),
            .i_pop  (rdrdys[j])
        );

        assign rddatas[j*B_DW +: B_DW] = w_word[j][BUS_DATA_OFS +: B_DW];
        assign rdaddrs[j*B_AW +: B_AW] = w_word[j][ADDR_OFS +: B_AW];
    end

`ifdef POWLIB_BUSROUTE_ERRCNT_EN
    logic          w_drop;
    logic [EW-1:0] r_errcnt;

    assign w_drop = w_xfer && !w_any;
    assign errcnt = r_errcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_errcnt <= '0;
        end else if (w_drop && (r_errcnt != '1)) begin
            r_errcnt <= r_errcnt + 1'b1;
        end
    end
`else
    assign errcnt = '0;
`endif

endmodule

// File: tb/tb_powlib_busroute.sv
// Directed, table-driven bench for powlib_busroute (4 ports, 4-bit address,
// 8-bit data, depth 2, windows 0/4/8/12 with sizes 4/4/4/2).
module tb_powlib_busroute;

`ifdef POWLIB_BUSROUTE_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wrdata;
    logic [3:0]  wraddr;
    logic        wrvld;
    logic        wrrdy;
    logic [31:0] rddatas;
    logic [15:0] rdaddrs;
    logic [3:0]  rdvlds;
    logic [3:0]  rdrdys;
    logic [7:0]  errcnt;

    powlib_busroute #(
        .ID      ("BUSROUTE"),
        .EDBG    (0),
        .B_RDS   (4),
        .B_AW    (4),
        .B_DW    (8),
        .D       (2),
        .EW      (8),
        .B_BASES (16'hC840),
        .B_SIZES (16'h2444)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wrdata  (wrdata),
        .wraddr  (wraddr),
        .wrvld   (wrvld),
        .wrrdy   (wrrdy),
        .rddatas (rddatas),
        .rdaddrs (rdaddrs),
        .rdvlds  (rdvlds),
        .rdrdys  (rdrdys),
        .errcnt  (errcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        vld;
        logic [3:0]  rdy;
        logic        e_rdy;
        logic [3:0]  e_vlds;
        logic [7:0]  e_err;
        logic [31:0] e_data;
        logic [15:0] e_addr;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic add(input logic [3:0] a, input logic [7:0] d, input logic v,
                       input logic [3:0] r, input logic er, input logic [3:0] ev,
                       input logic [7:0] ee, input logic [31:0] ed, input logic [15:0] ea);
        vec_t t;
        t.addr = a; t.data = d; t.vld = v; t.rdy = r; t.e_rdy = er;
        t.e_vlds = ev; t.e_err = ee; t.e_data = ed; t.e_addr = ea;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_err(input int unsigned n);
        if (!ERR_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lanes(input string tag, input logic [3:0] ev,
                             input logic [31:0] ed, input logic [15:0] ea);
        for (int j = 0; j < 4; j++) begin
            if (ev[j]) begin
                chk($sformatf("%s data%0d", tag, j), 32'(rddatas[j*8 +: 8]), 32'(ed[j*8 +: 8]));
                chk($sformatf("%s addr%0d", tag, j), 32'(rdaddrs[j*4 +: 4]), 32'(ea[j*4 +: 4]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; wrvld = 1'b0; wraddr = '0; wrdata = '0; rdrdys = 4'hF;
        #1 rst = 1'b0;
        #2;
        chk("reset wrrdy", 32'(wrrdy), 32'd0);
        chk("reset rdvlds", 32'(rdvlds), 32'd0);
        chk("reset errcnt", 32'(errcnt), 32'd0);
        #12 rst = 1'b1;
        tick();

        // Streaming with all outputs ready, then two unmatched addresses.
        add(4'd5,  8'hA5, 1, 4'hF, 1, 4'b0000, 0, 32'h0,         16'h0);
        add(4'd0,  8'h10, 1, 4'hF, 1, 4'b0010, 0, 32'h0000A500, 16'h0050);
        add(4'd4,  8'h11, 1, 4'hF, 1, 4'b0001, 0, 32'h00000010, 16'h0000);
        add(4'd8,  8'h12, 1, 4'hF, 1, 4'b0010, 0, 32'h00001100, 16'h0040);
        add(4'd12, 8'h13, 1, 4'hF, 1, 4'b0100, 0, 32'h00120000, 16'h0800);
        add(4'd0,  8'h14, 1, 4'hF, 1, 4'b1000, 0, 32'h13000000, 16'hC000);
        add(4'd4,  8'h15, 1, 4'hF, 1, 4'b0001, 0, 32'h00000014, 16'h0000);
        add(4'd8,  8'h16, 1, 4'hF, 1, 4'b0010, 0, 32'h00001500, 16'h0040);
        add(4'd13, 8'h17, 1, 4'hF, 1, 4'b0100, 0, 32'h00160000, 16'h0800);
        add(4'd14, 8'h18, 1, 4'hF, 1, 4'b1000, 0, 32'h17000000, 16'hD000);
        add(4'd15, 8'h19, 1, 4'hF, 1, 4'b0000, 1, 32'h0,         16'h0);
        add(4'd0,  8'h00, 0, 4'hF, 1, 4'b0000, 2, 32'h0,         16'h0);
        // Port 2 stalled: third beat to 9 holds the input, no pass-through on pop.
        add(4'd9,  8'h21, 1, 4'hB, 1, 4'b0000, 2, 32'h0,         16'h0);
        add(4'd9,  8'h22, 1, 4'hB, 1, 4'b0100, 2, 32'h00210000, 16'h0900);
        add(4'd9,  8'h23, 1, 4'hB, 0, 4'b0100, 2, 32'h00210000, 16'h0900);
        add(4'd9,  8'h23, 1, 4'hB, 0, 4'b0100, 2, 32'h00210000, 16'h0900);
        add(4'd9,  8'h23, 1, 4'hF, 0, 4'b0100, 2, 32'h00210000, 16'h0900);
        add(4'd9,  8'h23, 1, 4'hB, 1, 4'b0100, 2, 32'h00220000, 16'h0900);
        add(4'd1,  8'h31, 1, 4'hB, 1, 4'b0100, 2, 32'h00220000, 16'h0900);
        add(4'd0,  8'h00, 0, 4'hF, 1, 4'b0101, 2, 32'h00220031, 16'h0901);
        add(4'd0,  8'h00, 0, 4'hF, 1, 4'b0100, 2, 32'h00230000, 16'h0900);
        add(4'd0,  8'h00, 0, 4'hF, 1, 4'b0000, 2, 32'h0,         16'h0);
        // Full FIFO 0 with pop and push offered together.
        add(4'd0,  8'h41, 1, 4'hE, 1, 4'b0000, 2, 32'h0,         16'h0);
        add(4'd1,  8'h42, 1, 4'hE, 1, 4'b0001, 2, 32'h00000041, 16'h0000);
        add(4'd2,  8'h43, 1, 4'hF, 0, 4'b0001, 2, 32'h00000041, 16'h0000);
        add(4'd2,  8'h43, 1, 4'hE, 1, 4'b0001, 2, 32'h00000042, 16'h0001);
        add(4'd0,  8'h00, 0, 4'hF, 0, 4'b0001, 2, 32'h00000042, 16'h0001);
        add(4'd0,  8'h00, 0, 4'hF, 1, 4'b0001, 2, 32'h00000043, 16'h0002);
        add(4'd0,  8'h00, 0, 4'hF, 1, 4'b0000, 2, 32'h0,         16'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            wraddr = tbl[i].addr; wrdata = tbl[i].data;
            wrvld = tbl[i].vld; rdrdys = tbl[i].rdy;
            #4;
            chk($sformatf("v%0d wrrdy", i), 32'(wrrdy), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d rdvlds", i), 32'(rdvlds), 32'(tbl[i].e_vlds));
            chk($sformatf("v%0d errcnt", i), 32'(errcnt), 32'(exp_err(32'(tbl[i].e_err))));
            chk_lanes($sformatf("v%0d", i), tbl[i].e_vlds, tbl[i].e_data, tbl[i].e_addr);
            tick();
        end

        // Saturation: 300 further drops on top of the two already counted.
        wraddr = 4'd14; wrdata = 8'hEE; wrvld = 1'b1; rdrdys = 4'hF;
        repeat (252) tick();
        chk("sat 254", 32'(errcnt), 32'(exp_err(254)));
        tick();
        chk("sat 255", 32'(errcnt), 32'(exp_err(255)));
        repeat (47) tick();
        chk("sat hold", 32'(errcnt), 32'(exp_err(302)));
        chk("sat wrrdy", 32'(wrrdy), 32'd1);

        // Asynchronous reset with beats buffered in ports 0 and 1.
        rdrdys = 4'h0;
        wraddr = 4'd0; wrdata = 8'h51; tick();
        wraddr = 4'd4; wrdata = 8'h52; tick();
        wraddr = 4'd8; wrdata = 8'h53;
        #4;
        chk("pre-rst rdvlds", 32'(rdvlds), 32'b0011);
        rst = 1'b0;
        #1;
        chk("async rdvlds", 32'(rdvlds), 32'd0);
        chk("async wrrdy", 32'(wrrdy), 32'd0);
        chk("async errcnt", 32'(errcnt), 32'd0);
        @(posedge clk);
        #5;
        rst = 1'b1; wrvld = 1'b0; rdrdys = 4'hF; wraddr = 4'd0;
        #1;
        chk("post-rst wrrdy a0", 32'(wrrdy), 32'd1);
        wraddr = 4'd14;
        #1;
        chk("post-rst wrrdy a14", 32'(wrrdy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("no stale %0d", k), 32'(rdvlds), 32'd0);
        end
        wraddr = 4'd12; wrdata = 8'h61; wrvld = 1'b1;
        tick();
        wrvld = 1'b0;
        #1;
        chk("new beat rdvlds", 32'(rdvlds), 32'b1000);
        chk_lanes("new beat", 4'b1000, 32'h61000000, 16'hC000);
        chk("new beat errcnt", 32'(errcnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
